// File: rtl/awb_gain_ctrl.sv
// Gray-world auto-white-balance gain controller: accumulates Bayer channel sums per
// frame, then derives K_R/K_B with one shared restoring divider and applies them atomically.
`timescale 1ns/1ps
module awb_gain_ctrl #(
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned G_SHIFT  = 1,
  parameter logic [15:0] MAX_GAIN = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start_i,
  input  logic        frame_end_i,
  input  logic        valid_value_i,
  input  logic [1:0]  color_i,
  input  logic [7:0]  value_i,
  input  logic        freeze_i,
  output logic [15:0] K_R,
  output logic [15:0] K_G,
  output logic [15:0] K_B,
  output logic        valid_gain_o,
  output logic        gain_upd_o,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam int unsigned QW = ACC_W + 8;
  localparam int unsigned CW = $clog2(QW);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIV_R  = 2'd1;
  localparam logic [1:0] DIV_B  = 2'd2;
  localparam logic [1:0] UPDATE = 2'd3;
  localparam logic [15:0] UNITY = 16'h0100;

  logic [1:0]       state;
  logic [ACC_W-1:0] sum_r, sum_g, sum_b;
  logic [ACC_W-1:0] nxt_r, nxt_g, nxt_b, g_snap;
  logic [ACC_W-1:0] gn, dr, db, divisor;
  logic [QW-1:0]    quo, quo_nx;
  logic [ACC_W-1:0] rem, rem_nx;
  logic [ACC_W:0]   rem_sh;
  logic             ge, last;
  logic [CW-1:0]    cnt;
  logic [15:0]      gain_r, gain_b, gain_nx, k_r, k_b;
  logic             upd, overrun;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] base,
                                               input logic [7:0] v);
    logic [ACC_W:0] s;
    s = {1'b0, base} + {{(ACC_W-7){1'b0}}, v};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  // Clear happens before the add so a pixel coincident with frame_start starts the new sum.
  always_comb begin
    nxt_r = frame_start_i ? '0 : sum_r;
    nxt_g = frame_start_i ? '0 : sum_g;
    nxt_b = frame_start_i ? '0 : sum_b;
    if (valid_value_i) begin
      case (color_i)
        2'b00:   nxt_r = sat_add(nxt_r, value_i);
        2'b10:   nxt_b = sat_add(nxt_b, value_i);
        default: nxt_g = sat_add(nxt_g, value_i);
      endcase
    end
  end

  assign g_snap  = nxt_g >> G_SHIFT;
  assign divisor = (state == DIV_B) ? db : dr;
  assign rem_sh  = {rem, quo[QW-1]};
  assign ge      = rem_sh >= {1'b0, divisor};
  assign rem_nx  = ge ? ACC_W'(rem_sh - {1'b0, divisor}) : rem_sh[ACC_W-1:0];
  assign quo_nx  = {quo[QW-2:0], ge};
  assign last    = (cnt == CW'(QW - 1));
  assign gain_nx = (divisor == '0) ? UNITY :
                   (quo_nx > QW'(MAX_GAIN)) ? MAX_GAIN : quo_nx[15:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sum_r   <= '0;
      sum_g   <= '0;
      sum_b   <= '0;
      gn      <= '0;
      dr      <= '0;
      db      <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
      gain_r  <= UNITY;
      gain_b  <= UNITY;
      k_r     <= UNITY;
      k_b     <= UNITY;
      upd     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sum_r <= nxt_r;
      sum_g <= nxt_g;
      sum_b <= nxt_b;
      upd   <= 1'b0;
      if (frame_end_i && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_end_i) begin
            gn    <= g_snap;
            dr    <= nxt_r;
            db    <= nxt_b;
            quo   <= {g_snap, 8'h00};
            rem   <= '0;
            cnt   <= '0;
            state <= DIV_R;
          end
        end
        DIV_R: begin
          quo <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt + CW'(1);
          // Last red iteration: latch the result and reload the dividend for blue.
          if (last) begin
            gain_r <= gain_nx;
            quo    <= {gn, 8'h00};
            rem    <= '0;
            cnt    <= '0;
            state  <= DIV_B;
          end
        end
        DIV_B: begin
          quo <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            gain_b <= gain_nx;
            state  <= UPDATE;
          end
        end
        UPDATE: begin
          if (!freeze_i) begin
            k_r <= gain_r;
            k_b <= gain_b;
            upd <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign K_R          = k_r;
  assign K_G          = UNITY;
  assign K_B          = k_b;
  assign valid_gain_o = 1'b1;
  assign gain_upd_o   = upd;
  assign busy_o       = (state != IDLE);
  assign overrun_o    = overrun;

endmodule

// File: tb/tb_awb_gain_ctrl.sv
// Self-checking bench for awb_gain_ctrl: table frames, hand-written corner sequences,
// and random frames checked against a gray-world arithmetic model.
`timescale 1ns/1ps
module tb_awb_gain_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, frame_start, frame_end, valid, freeze;
  logic [1:0]  color;
  logic [7:0]  value;
  logic [15:0] k_r, k_g, k_b, k8_r, k8_g, k8_b;
  logic        vgain, upd, busy, overrun, v8, u8, b8, o8;

  int n_assert = 0;
  int n_fail   = 0;
  longint m_r, m_g, m_b;
  logic [15:0] cur_kr, cur_kb;

  typedef struct {
    int rc; int rv; int gc; int gv; int bc; int bv;
    logic [15:0] kr; logic [15:0] kb;
  } vec_t;
  vec_t tbl[6];

  awb_gain_ctrl #(.ACC_W(32), .G_SHIFT(1), .MAX_GAIN(16'h0800)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start), .frame_end_i(frame_end),
    .valid_value_i(valid), .color_i(color), .value_i(value), .freeze_i(freeze),
    .K_R(k_r), .K_G(k_g), .K_B(k_b), .valid_gain_o(vgain), .gain_upd_o(upd),
    .busy_o(busy), .overrun_o(overrun));

  // Narrow accumulators so channel saturation is reachable in a few pixels.
  awb_gain_ctrl #(.ACC_W(8), .G_SHIFT(1), .MAX_GAIN(16'h0800)) dut8 (
    .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start), .frame_end_i(frame_end),
    .valid_value_i(valid), .color_i(color), .value_i(value), .freeze_i(freeze),
    .K_R(k8_r), .K_G(k8_g), .K_B(k8_b), .valid_gain_o(v8), .gain_upd_o(u8),
    .busy_o(b8), .overrun_o(o8));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint sat32(input longint s);
    return (s > 64'd4294967295) ? 64'd4294967295 : s;
  endfunction

  function automatic logic [15:0] mgain(input longint g, input longint d);
    longint q;
    if (d == 0) return 16'h0100;
    q = (g * 256) / d;
    if (q > 2048) return 16'h0800;
    return q[15:0];
  endfunction

  task automatic model_add(input logic [1:0] c, input logic [7:0] v);
    if (c == 2'b00)      m_r = sat32(m_r + v);
    else if (c == 2'b10) m_b = sat32(m_b + v);
    else                 m_g = sat32(m_g + v);
  endtask

  task automatic pixel(input logic [1:0] c, input logic [7:0] v);
    valid = 1'b1; color = c; value = v;
    model_add(c, v);
    step();
    valid = 1'b0;
  endtask

  task automatic frame_begin();
    frame_start = 1'b1; m_r = 0; m_g = 0; m_b = 0;
    step();
    frame_start = 1'b0;
  endtask

  task automatic add_pixels(input int rc, input int rv, input int gc, input int gv,
                            input int bc, input int bv);
    for (int i = 0; i < rc; i++) pixel(2'b00, rv[7:0]);
    for (int i = 0; i < gc; i++) pixel((i % 2) ? 2'b11 : 2'b01, gv[7:0]);
    for (int i = 0; i < bc; i++) pixel(2'b10, bv[7:0]);
  endtask

  // Issue frame_end (optionally with a coincident R pixel) and watch the full sequence.
  task automatic finish_frame(input string tag, input bit frz, input bit cp, input logic [7:0] cv,
                              input logic [15:0] er, input logic [15:0] eb);
    int busy_n, upd_n, upd_at, partial;
    logic [15:0] xr, xb;
    freeze = frz; frame_end = 1'b1;
    if (cp) begin valid = 1'b1; color = 2'b00; value = cv; model_add(2'b00, cv); end
    step();
    frame_end = 1'b0; valid = 1'b0;
    busy_n = 0; upd_n = 0; upd_at = -1; partial = 0;
    for (int k = 0; k < 90; k++) begin
      if (busy) busy_n++;
      if (upd) begin upd_n++; upd_at = k; end
      if (k <= 80 && (k_r !== cur_kr || k_b !== cur_kb || k_g !== 16'h0100)) partial++;
      step();
    end
    freeze = 1'b0;
    xr = frz ? cur_kr : er;
    xb = frz ? cur_kb : eb;
    check({tag, " busy cycles"}, busy_n, 81);
    check({tag, " upd pulses"}, upd_n, frz ? 0 : 1);
    if (upd_n == 1) check({tag, " upd edge"}, upd_at, 81);
    check({tag, " early K change"}, partial, 0);
    check({tag, " K_R"}, k_r, xr);
    check({tag, " K_G"}, k_g, 16'h0100);
    check({tag, " K_B"}, k_b, xb);
    cur_kr = k_r; cur_kb = k_b;
  endtask

  initial begin
    tbl[0] = '{4, 64, 8, 128, 4, 32,  16'h0200, 16'h0400};
    tbl[1] = '{0, 0,  8, 128, 4, 8,   16'h0100, 16'h0800};
    tbl[2] = '{4, 128, 8, 128, 4, 128, 16'h0100, 16'h0100};
    tbl[3] = '{2, 255, 4, 10, 1, 1,   16'h000A, 16'h0800};
    tbl[4] = '{4, 64, 0, 0, 2, 5,     16'h0000, 16'h0000};
    tbl[5] = '{1, 1,  3, 1,  3, 1,    16'h0100, 16'h0055};

    rst_n = 1'b0; frame_start = 0; frame_end = 0; valid = 0; freeze = 0;
    color = '0; value = '0; m_r = 0; m_g = 0; m_b = 0;
    cur_kr = 16'h0100; cur_kb = 16'h0100;
    repeat (3) step();
    rst_n = 1'b1;
    check("reset K_R", k_r, 16'h0100);
    check("reset K_G", k_g, 16'h0100);
    check("reset K_B", k_b, 16'h0100);
    check("reset valid_gain", vgain, 1'b1);
    check("reset upd", upd, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset overrun", overrun, 1'b0);

    for (int t = 0; t < 6; t++) begin
      frame_begin();
      add_pixels(tbl[t].rc, tbl[t].rv, tbl[t].gc, tbl[t].gv, tbl[t].bc, tbl[t].bv);
      finish_frame($sformatf("tbl%0d", t), 1'b0, 1'b0, 8'd0, tbl[t].kr, tbl[t].kb);
    end

    // Overrun: second frame streams and ends while the first is still dividing.
    frame_begin();
    add_pixels(4, 64, 8, 128, 4, 32);
    frame_end = 1'b1; step(); frame_end = 1'b0;
    repeat (19) step();
    frame_begin();
    add_pixels(4, 32, 8, 128, 4, 64);
    frame_end = 1'b1; step(); frame_end = 1'b0;
    check("ovr busy at 2nd end", busy, 1'b1);
    check("ovr flag set", overrun, 1'b1);
    for (int i = 0; i < 150 && busy; i++) step();
    check("ovr wait timeout", busy, 1'b0);
    check("ovr first K_R", k_r, 16'h0200);
    check("ovr first K_B", k_b, 16'h0400);
    cur_kr = k_r; cur_kb = k_b;
    finish_frame("ovr later frame", 1'b0, 1'b0, 8'd0, 16'h0400, 16'h0200);
    check("ovr sticky", overrun, 1'b1);

    frame_begin();
    add_pixels(4, 32, 8, 128, 4, 32);
    finish_frame("freeze", 1'b1, 1'b0, 8'd0, 16'h0400, 16'h0400);

    frame_begin();
    add_pixels(1, 1, 8, 128, 0, 0);
    finish_frame("coincident R", 1'b0, 1'b1, 8'd255, 16'h0200, 16'h0100);

    frame_begin();
    add_pixels(2, 255, 2, 100, 1, 50);
    finish_frame("sat frame", 1'b0, 1'b0, 8'd0, 16'h0032, 16'h0200);
    check("sat8 K_R", k8_r, 16'h0064);
    check("sat8 K_B", k8_b, 16'h0200);

    for (int f = 0; f < 8; f++) begin
      bit frz;
      int len;
      frame_begin();
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) != 0) pixel(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        else step();
      end
      frz = ($urandom_range(0, 3) == 0);
      finish_frame($sformatf("rand%0d", f), frz, 1'b0, 8'd0,
                   mgain(m_g >> 1, m_r), mgain(m_g >> 1, m_b));
    end

    // Reset 30 cycles into DIV_R aborts the division.
    frame_begin();
    add_pixels(4, 64, 8, 128, 4, 128);
    frame_end = 1'b1; step(); frame_end = 1'b0;
    repeat (30) step();
    check("pre-reset busy", busy, 1'b1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("rst busy", busy, 1'b0);
    check("rst K_R", k_r, 16'h0100);
    check("rst K_B", k_b, 16'h0100);
    check("rst upd", upd, 1'b0);
    check("rst overrun", overrun, 1'b0);
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
        if (upd) pulses++;
        step();
      end
      check("rst no late upd", pulses, 0);
      check("rst K_R held", k_r, 16'h0100);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
